pc_gen: RTL

Program-counter generator for the single-cycle RISC-V core. Holds the architectural PC, drives it to the `PCplus4` adder and the instruction-memory address port, and selects the next PC from the adder result, the branch target, or the JALR target. A small FSM sequences post-reset start-up, fetch handshakes with instruction memory, stalls, and a one-cycle trap redirect on misaligned targets.

---
 rtl/pc_gen.sv | 89 ++++++++
 1 files changed

// File: rtl/pc_gen.sv
//------------------------------------------------------------------------------
// Module      : pc_gen
// Description : Program-counter generator with start-up, fetch and trap FSM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_gen #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcp4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jalr_en,
    input  logic [31:0] jalr_target,
    input  logic        stall,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic        instr_valid,
    output logic        misaligned,
    output logic [31:0] bad_pc
);

    localparam logic [1:0] c_st_reset = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_trap  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_bad_pc;
    logic [31:0] w_next_pc;
    logic        w_req;
    logic        w_valid;
    logic        w_trap;

    // JALR has priority over a taken branch; its bit 0 is always cleared.
    always_comb begin
        w_next_pc = pcp4;
        if (jalr_en) begin
            w_next_pc = {jalr_target[31:1], 1'b0};
        end else if (branch_taken) begin
            w_next_pc = branch_target;
        end
    end

    assign w_req   = (r_state == c_st_fetch) & ~stall;
    assign w_valid = w_req & imem_ready;
    assign w_trap  = w_valid & (w_next_pc[1:0] != 2'b00);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_reset: w_state_nxt = c_st_fetch;
            c_st_fetch: if (w_trap) w_state_nxt = c_st_trap;
            c_st_trap:  w_state_nxt = c_st_fetch;
            default:    w_state_nxt = c_st_reset;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_reset;
            r_pc     <= RESET_VECTOR;
            r_bad_pc <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_trap) begin
                r_bad_pc <= w_next_pc;
                r_pc     <= TRAP_VECTOR;
            end else if (w_valid) begin
                r_pc <= w_next_pc;
            end
        end
    end

    assign pc          = r_pc;
    assign bad_pc      = r_bad_pc;
    assign imem_req    = w_req;
    assign instr_valid = w_valid;
    assign misaligned  = (r_state == c_st_trap);

endmodule

`default_nettype wire
